// File: rtl/bram_portb_arbiter_if.sv
// ---------------------------------------------------------------------------
// bram_portb_arbiter_if
//   Bundle between the BRAM port-B arbiter, its peripheral requesters and the
//   BRAM port B itself.
//
//   Requester side : req, req_we, req_addr, req_wdata  (into the arbiter)
//                    gnt, rvalid, rdata, busy          (out of the arbiter)
//   BRAM side      : addr_b, data_b, we_b              (out of the arbiter)
//                    q_b                               (into the arbiter)
//
//   Per-requester fields are packed [NUM_REQ-1:0][W-1:0], so requester i sits
//   at bits [i*W +: W] of the flattened vector.
//
//   Modports:
//     slave  - the arbiter
//     master - everything around it (requesters and the BRAM model/macro)
// ---------------------------------------------------------------------------
interface bram_portb_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0]             req_we;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]             gnt;
    logic [NUM_REQ-1:0]             rvalid;
    logic [DATA_W-1:0]              rdata;
    logic [ADDR_W-1:0]              addr_b;
    logic [DATA_W-1:0]              data_b;
    logic                           we_b;
    logic [DATA_W-1:0]              q_b;
    logic                           busy;

    modport slave (
        input  req, req_we, req_addr, req_wdata, q_b,
        output gnt, rvalid, rdata, addr_b, data_b, we_b, busy
    );

    modport master (
        output req, req_we, req_addr, req_wdata, q_b,
        input  gnt, rvalid, rdata, addr_b, data_b, we_b, busy
    );
endinterface

// File: rtl/bram_portb_arbiter.sv
// ---------------------------------------------------------------------------
// bram_portb_arbiter
//   Shares BRAM port B between NUM_REQ peripheral requesters (VGA fetch,
//   controller input writer, score display, ...). One single-word access is
//   in flight at a time:
//     IDLE  -> pick a winner, register address/data/we and the grant
//     ISSUE -> gnt pulse; BRAM samples addr_b/data_b/we_b at the end
//     WAIT  -> (reads only) rvalid pulse, rdata = q_b
//
//   Ports:
//     clk    - system clock
//     reset  - synchronous, active-high
//     bus    - bram_portb_arbiter_if.slave (request/grant/read-return and
//              the BRAM port B address/data/write-enable/read-data)
//
//   Build option:
//     BRAMB_ARB_PRIO0_EN - requester 0 wins whenever it asks; round-robin
//                          only among the others, and a requester-0 grant
//                          leaves the round-robin pointer untouched.
// ---------------------------------------------------------------------------

// Per-requester grant / read-valid flags. gnt_q is high only during ISSUE of
// this lane's transaction, so "ret & gnt_q" marks exactly the lane whose read
// is heading into WAIT.
module bramb_arb_lane (
    input  logic clk,
    input  logic reset,
    input  logic take,
    input  logic ret,
    output logic gnt_q,
    output logic rvalid_q
);
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            gnt_q    <= take;
            rvalid_q <= ret & gnt_q;
        end
    end
endmodule

module bram_portb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    bram_portb_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } breq_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    win_idx;
    logic                win_found;
    breq_t               sel;

    logic                take, ret, rr_load, we_clr;
    logic [NUM_REQ-1:0]  gnt_q, rvalid_q;

    logic [ADDR_W-1:0]   addr_b_q;
    logic [DATA_W-1:0]   data_b_q;
    logic                we_b_q;

    // (base + k) mod NUM_REQ for k in 1..NUM_REQ, without a divider.
    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                                input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    // ---------------------------------------------------------------------
    // Winner select: first requester found scanning upward from rr_ptr+1.
    // ---------------------------------------------------------------------
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && bus.req[rr_idx(rr_ptr, k)]) begin
                win_idx   = rr_idx(rr_ptr, k);
                win_found = 1'b1;
            end
        end
`ifdef BRAMB_ARB_PRIO0_EN
        // VGA fetch overrides the rotation whenever it asks.
        if (bus.req[0]) begin
            win_idx   = '0;
            win_found = 1'b1;
        end
`endif
    end

    assign sel = '{we:    bus.req_we[win_idx],
                   addr:  bus.req_addr[win_idx],
                   wdata: bus.req_wdata[win_idx]};

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (win_found) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = we_b_q ? S_IDLE : S_WAIT;
            S_WAIT:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs (load/clear strobes for the datapath and lanes)
    // ---------------------------------------------------------------------
    always_comb begin
        take    = 1'b0;
        ret     = 1'b0;
        rr_load = 1'b0;
        we_clr  = 1'b0;
        case (state)
            S_IDLE: begin
                take = win_found;
`ifdef BRAMB_ARB_PRIO0_EN
                // With req[0] low the scan never lands on 0, so a zero
                // winner always means the priority override fired.
                rr_load = win_found && (win_idx != '0);
`else
                rr_load = win_found;
`endif
            end
            S_ISSUE: begin
                we_clr = 1'b1;
                ret    = ~we_b_q;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: port B drive registers and round-robin pointer
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= IDX_W'(NUM_REQ - 1);
            addr_b_q <= '0;
            data_b_q <= '0;
            we_b_q   <= 1'b0;
        end else begin
            if (rr_load) rr_ptr <= win_idx;
            if (take) begin
                addr_b_q <= sel.addr;
                data_b_q <= sel.wdata;
                we_b_q   <= sel.we;
            end else if (we_clr) begin
                we_b_q   <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Per-requester grant / read-valid lanes
    // ---------------------------------------------------------------------
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        bramb_arb_lane u_lane (
            .clk      (clk),
            .reset    (reset),
            .take     (take && (win_idx == IDX_W'(i))),
            .ret      (ret),
            .gnt_q    (gnt_q[i]),
            .rvalid_q (rvalid_q[i])
        );
    end

    assign bus.gnt    = gnt_q;
    // A reset landing in WAIT drops the read: suppress the pulse right away
    // rather than letting it show for the reset cycle.
    assign bus.rvalid = rvalid_q & {NUM_REQ{~reset}};
    assign bus.rdata  = bus.q_b;
    assign bus.addr_b = addr_b_q;
    assign bus.data_b = data_b_q;
    assign bus.we_b   = we_b_q;
    assign bus.busy   = (state != S_IDLE);

endmodule
